mdu_seq_ctrl: RTL

//  Multi-cycle sequencer for RV64M mul/div in EXU; replaces single-cycle combinational MDU path.

---
 rtl/mdu_seq_ctrl_pkg.sv | 40 ++++
 rtl/mdu_seq_ctrl_if.sv | 26 ++
 rtl/mdu_div_iter.sv | 57 +++++
 rtl/mdu_seq_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mdu_seq_ctrl_pkg.sv
// rtl/mdu_seq_ctrl_pkg.sv - widths, M-extension op encodings and FSM states for the MDU sequencer
package mdu_seq_ctrl_pkg;

    localparam int XLEN  = 64;
    localparam int HXLEN = 32;
    localparam int DXLEN = 128;
    localparam int CNT_W = 7;

    // {inst_32, funct3}
    typedef enum logic [3:0] {
        OP_MUL    = 4'b0000,
        OP_MULH   = 4'b0001,
        OP_MULHSU = 4'b0010,
        OP_MULHU  = 4'b0011,
        OP_DIV    = 4'b0100,
        OP_DIVU   = 4'b0101,
        OP_REM    = 4'b0110,
        OP_REMU   = 4'b0111,
        OP_MULW   = 4'b1000,
        OP_DIVW   = 4'b1100,
        OP_DIVUW  = 4'b1101,
        OP_REMW   = 4'b1110,
        OP_REMUW  = 4'b1111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] D_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] W_MIN = {{(HXLEN+1){1'b1}}, {(HXLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_w(input logic [HXLEN-1:0] v);
        return {{HXLEN{v[HXLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl_if.sv
// rtl/mdu_seq_ctrl_if.sv - request/result handshake bundle between EXU and the MDU sequencer
interface mdu_seq_ctrl_if;
    import mdu_seq_ctrl_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] x_rs1;
    logic [XLEN-1:0] x_rs2;
    logic [2:0]      funct3;
    logic            inst_32;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] mdu_result;
    logic            busy;

    modport master (
        output flush, in_valid, x_rs1, x_rs2, funct3, inst_32, out_ready,
        input  in_ready, out_valid, mdu_result, busy
    );

    modport slave (
        input  flush, in_valid, x_rs1, x_rs2, funct3, inst_32, out_ready,
        output in_ready, out_valid, mdu_result, busy
    );
endinterface

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - restoring shift-subtract divider on unsigned magnitudes, one quotient bit per cycle
module mdu_div_iter
    import mdu_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             start,
    input  logic [CNT_W-1:0] n_iter,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    output logic [XLEN-1:0]  quot,
    output logic [XLEN-1:0]  rem,
    output logic             done
);
    logic [XLEN-1:0]  rem_q, quot_q, div_q;
    logic [XLEN-1:0]  cur_rem, cur_quot, cur_div;
    logic [CNT_W-1:0] cnt_q, n_q;
    logic             run_q, fits;
    logic [XLEN:0]    shifted, diff;

    // The start cycle already performs the first iteration on the incoming operands;
    // the dividend is pre-shifted so only n_iter bits pass through the remainder.
    always_comb begin
        cur_rem  = start ? '0 : rem_q;
        cur_quot = start ? (dividend << (CNT_W'(XLEN) - n_iter)) : quot_q;
        cur_div  = start ? divisor : div_q;
        shifted  = {cur_rem, cur_quot[XLEN-1]};
        diff     = shifted - {1'b0, cur_div};
        fits     = ~diff[XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            n_q    <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
        end else if (start || (run_q && !done)) begin
            rem_q  <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            quot_q <= {cur_quot[XLEN-2:0], fits};
            cnt_q  <= start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (start) begin
                n_q   <= n_iter;
                div_q <= divisor;
                run_q <= 1'b1;
            end
        end
    end

    assign done = run_q && (cnt_q == n_q);
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// rtl/mdu_seq_ctrl.sv - multi-cycle RV64M mul/div sequencer, one op in flight, result held until accepted
module mdu_seq_ctrl
    import mdu_seq_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    mdu_seq_ctrl_if.slave m
);
    state_t           state;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [3:0]       op_q, in_op, mul_op;
    logic [XLEN-1:0]  a_q, b_q, result;
    logic             neg_q, neg_r, out_valid;

    logic             in_w, in_div, in_rem, in_sgn, in_illegal, div0, ovf, start;
    logic [XLEN-1:0]  a_eff, b_eff, a_mag, b_mag, special_res;
    logic [XLEN-1:0]  mul_a, mul_b, mul_res;
    logic [DXLEN-1:0] mul_ax, mul_bx, prod;
    logic [XLEN-1:0]  quot, rem, q_fix, r_fix, div_res;
    logic             div_done;

    always_comb begin
        in_op      = {m.inst_32, m.funct3};
        in_w       = m.inst_32;
        in_div     = m.funct3[2];
        in_rem     = m.funct3[1];
        in_sgn     = ~m.funct3[0];
        in_illegal = in_w & ~in_div & (m.funct3[1:0] != 2'b00);
        a_eff      = m.x_rs1;
        b_eff      = m.x_rs2;
        if (in_w) begin
            a_eff = in_sgn ? sext_w(m.x_rs1[HXLEN-1:0]) : {{HXLEN{1'b0}}, m.x_rs1[HXLEN-1:0]};
            b_eff = in_sgn ? sext_w(m.x_rs2[HXLEN-1:0]) : {{HXLEN{1'b0}}, m.x_rs2[HXLEN-1:0]};
        end
        div0  = (b_eff == '0);
        ovf   = in_sgn & (a_eff == (in_w ? W_MIN : D_MIN)) & (b_eff == '1);
        a_mag = (in_sgn & a_eff[XLEN-1]) ? -a_eff : a_eff;
        b_mag = (in_sgn & b_eff[XLEN-1]) ? -b_eff : b_eff;
        // On MIN / -1 the quotient equals the (already extended) dividend.
        if (in_illegal)  special_res = '0;
        else if (div0)   special_res = in_rem ? a_eff : '1;
        else             special_res = in_rem ? '0 : a_eff;
        if (in_w)        special_res = sext_w(special_res[HXLEN-1:0]);
    end

    // Product from latched operands; with single-cycle latency it must see the request directly.
    always_comb begin
        mul_op = (MUL_LAT == 1) ? in_op   : op_q;
        mul_a  = (MUL_LAT == 1) ? m.x_rs1 : a_q;
        mul_b  = (MUL_LAT == 1) ? m.x_rs2 : b_q;
        mul_ax = {{XLEN{((mul_op == OP_MULH) || (mul_op == OP_MULHSU)) & mul_a[XLEN-1]}}, mul_a};
        mul_bx = {{XLEN{(mul_op == OP_MULH) & mul_b[XLEN-1]}}, mul_b};
        prod   = mul_ax * mul_bx;
        case (mul_op)
            OP_MUL:  mul_res = prod[XLEN-1:0];
            OP_MULW: mul_res = sext_w(prod[HXLEN-1:0]);
            default: mul_res = prod[DXLEN-1:XLEN];
        endcase
    end

    always_comb begin
        q_fix   = neg_q ? -quot : quot;
        r_fix   = neg_r ? -rem  : rem;
        div_res = op_q[1] ? r_fix : q_fix;
        if (op_q[3]) div_res = sext_w(div_res[HXLEN-1:0]);
    end

    assign cnt_inc = cnt + CNT_W'(1);
    assign start   = m.in_valid & m.in_ready & ~rst & in_div & ~div0 & ~ovf;

    mdu_div_iter u_div (
        .clk      (clk),
        .rst      (rst),
        .kill     (m.flush),
        .start    (start),
        .n_iter   (in_w ? CNT_W'(HXLEN) : CNT_W'(XLEN)),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quot     (quot),
        .rem      (rem),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (m.flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (m.in_valid) begin
                    cnt   <= '0;
                    op_q  <= in_op;
                    a_q   <= m.x_rs1;
                    b_q   <= m.x_rs2;
                    neg_q <= in_sgn & (a_eff[XLEN-1] ^ b_eff[XLEN-1]);
                    neg_r <= in_sgn & a_eff[XLEN-1];
                    if (in_illegal || (in_div && (div0 || ovf))) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= special_res;
                    end else if (in_div) begin
                        state <= S_DIV;
                    end else if (MUL_LAT == 1) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= mul_res;
                    end else begin
                        state <= S_MUL;
                    end
                end
                S_MUL: if (cnt_inc == CNT_W'(MUL_LAT - 1)) begin
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                    result    <= mul_res;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
                S_DIV: if (div_done) begin
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                    result    <= div_res;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
                S_DONE: if (m.out_ready) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m.in_ready   = (state == S_IDLE) & ~m.flush;
    assign m.out_valid  = out_valid;
    assign m.mdu_result = result;
    assign m.busy       = (state != S_IDLE);

endmodule
